// File: rtl/csh_fill_seq_pkg.sv
// Shared types and helpers for the cache lookup/refill sequencer.
// Sizes assume a 4-way cache with 4-word lines.
package csh_pkg;

  localparam int WAYS  = 4;
  localparam int WORDS = 4;

  typedef logic [1:0] way_idx_t;
  typedef logic [1:0] wd_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_MREQ   = 3'd3,
    ST_FILL   = 3'd4,
    ST_DIRWR  = 3'd5,
    ST_USE    = 3'd6
  } csh_fill_st_t;

  typedef struct packed {
    way_idx_t way;
    logic     multi;
  } way_enc_t;

  function automatic logic [WORDS-1:0] onehot_wd(input wd_idx_t idx);
    logic [WORDS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Lowest set bit wins the encoding; multi flags more than one match.
  function automatic way_enc_t enc_way(input logic [WAYS-1:0] vec);
    way_enc_t r;
    int       n;
    r.way   = '0;
    r.multi = 1'b0;
    n       = 0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.way = way_idx_t'(i);
        n     = n + 1;
      end
    end
    r.multi = (n > 1);
    return r;
  endfunction

endpackage

// File: rtl/csh_fill_seq_if.sv
// Directory / memory / write-back signal bundle of the refill sequencer.
// The sequencer drives the master side; directory and memory sit on the slave side.
interface csh_fill_seq_if;
  import csh_pkg::*;

  // Handshakes: csh_req_h is a level sampled only while csh_busy_h is low
  // (one accept per transaction); mem_rd_req_h is held high until the cycle
  // mem_ack_h is seen, after which each mem_data_vld_h cycle carries one word.
  logic         csh_req_h;
  logic [1:0]   csh_req_wd_h;
  logic [3:0]   csh_valid_match_h;
  logic [1:0]   csh_lru_h;
  logic         csh_adr_par_bad_l;
  logic         mem_ack_h;
  logic         mem_data_vld_h;
  logic         mem_nxm_h;

  logic         csh_busy_h;
  logic         csh_hit_h;
  logic [1:0]   csh_hit_way_h;
  logic         mem_rd_req_h;
  logic [1:0]   mem_rd_wd_h;
  logic [3:0]   csh_wr_en_l;
  logic [3:0]   csh_wr_wd_en_h;
  logic         csh_val_wr_pulse_l;
  logic         csh_val_wr_data_h;
  logic         csh_refill_ram_wr_l;
  logic         csh_use_wr_en_h;
  logic         csh_fill_done_h;
  logic [1:0]   csh_err_h;
  csh_fill_st_t dbg_state;

  modport master (
    input  csh_req_h, csh_req_wd_h, csh_valid_match_h, csh_lru_h,
           csh_adr_par_bad_l, mem_ack_h, mem_data_vld_h, mem_nxm_h,
    output csh_busy_h, csh_hit_h, csh_hit_way_h, mem_rd_req_h, mem_rd_wd_h,
           csh_wr_en_l, csh_wr_wd_en_h, csh_val_wr_pulse_l, csh_val_wr_data_h,
           csh_refill_ram_wr_l, csh_use_wr_en_h, csh_fill_done_h, csh_err_h,
           dbg_state
  );

  modport slave (
    output csh_req_h, csh_req_wd_h, csh_valid_match_h, csh_lru_h,
           csh_adr_par_bad_l, mem_ack_h, mem_data_vld_h, mem_nxm_h,
    input  csh_busy_h, csh_hit_h, csh_hit_way_h, mem_rd_req_h, mem_rd_wd_h,
           csh_wr_en_l, csh_wr_wd_en_h, csh_val_wr_pulse_l, csh_val_wr_data_h,
           csh_refill_ram_wr_l, csh_use_wr_en_h, csh_fill_done_h, csh_err_h,
           dbg_state
  );
endinterface

// File: rtl/csh_fill_seq_tmo.sv
// Memory-wait watchdog: counts idle cycles while enabled, cleared on any
// memory activity, and flags expiry once the count reaches TIMEOUT_CYC.
module csh_fill_tmo #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst_l,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [7:0] TMO_MAX = 8'(TIMEOUT_CYC);

  logic [7:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == TMO_MAX);

endmodule

// File: rtl/csh_fill_seq.sv
// Cache lookup/refill sequencer: reports hits, and on a miss fetches a
// wrap-ordered line into the victim way and writes the directory back.
module csh_fill_seq
  import csh_pkg::*;
#(
  parameter int SETTLE_CYC  = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk_mbx_h,
  input  logic          mr_reset_l,
  csh_fill_seq_if.master bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  csh_fill_st_t r_state;
  csh_fill_st_t w_state_nxt;
  wd_idx_t      r_wd;
  way_idx_t     r_way;
  logic [1:0]   r_n;
  logic [7:0]   r_settle;
  logic [1:0]   r_err;

  way_enc_t     w_enc;
  logic         w_lkp_err;
  logic         w_hit;
  logic         w_mem_st;
  logic         w_tmo_exp;
  logic         w_tmo_clr;
  logic         w_abort;
  logic         w_beat;
  logic         w_last_beat;
  wd_idx_t      w_beat_wd;

  logic         w_hit_o;
  way_idx_t     w_hit_way;
  logic         w_rd_req;
  wd_idx_t      w_rd_wd;
  logic [3:0]   w_wr_en_l;
  logic [3:0]   w_wd_en;
  logic         w_val_pulse_l;
  logic         w_val_data;
  logic         w_refill_l;
  logic         w_use;
  logic         w_done;

  // A parity error or multiple matching ways can't be trusted as a hit.
  assign w_enc       = enc_way(bus.csh_valid_match_h);
  assign w_lkp_err   = w_enc.multi || !bus.csh_adr_par_bad_l;
  assign w_hit       = (r_state == ST_LOOKUP) && (bus.csh_valid_match_h != 4'b0000) && !w_lkp_err;
  assign w_mem_st    = (r_state == ST_MREQ) || (r_state == ST_FILL);
  assign w_tmo_clr   = !w_mem_st || bus.mem_ack_h || bus.mem_data_vld_h;
  assign w_abort     = w_mem_st && (bus.mem_nxm_h || w_tmo_exp);
  assign w_beat      = (r_state == ST_FILL) && bus.mem_data_vld_h && !w_abort;
  assign w_last_beat = w_beat && (r_n == 2'd3);
  assign w_beat_wd   = r_wd + r_n;

  csh_fill_tmo #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .i_clk    (clk_mbx_h),
    .i_rst_l  (mr_reset_l),
    .i_clr    (w_tmo_clr),
    .i_en     (w_mem_st),
    .o_expire (w_tmo_exp)
  );

  always_ff @(posedge clk_mbx_h) begin
    if (!mr_reset_l) begin
      r_state  <= ST_IDLE;
      r_wd     <= '0;
      r_way    <= '0;
      r_n      <= 2'd0;
      r_settle <= 8'd0;
      r_err    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && bus.csh_req_h) r_wd <= bus.csh_req_wd_h;
      r_settle <= (r_state == ST_SETTLE) ? r_settle + 8'd1 : 8'd0;
      if (r_state == ST_LOOKUP) begin
        r_way <= w_hit ? w_enc.way : bus.csh_lru_h;
        if (w_lkp_err) r_err[0] <= 1'b1;
      end
      if (r_state != ST_FILL) r_n <= 2'd0;
      else if (w_beat)        r_n <= r_n + 2'd1;
      if (w_abort) r_err[1] <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.csh_req_h) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_settle == SETTLE_LAST) w_state_nxt = ST_LOOKUP;
      ST_LOOKUP: w_state_nxt = w_hit ? ST_USE : ST_MREQ;
      ST_MREQ: begin
        if (w_abort)             w_state_nxt = ST_IDLE;
        else if (bus.mem_ack_h)  w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (w_abort)          w_state_nxt = ST_IDLE;
        else if (w_last_beat) w_state_nxt = ST_DIRWR;
      end
      ST_DIRWR:  w_state_nxt = ST_USE;
      ST_USE:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Aborts invalidate the victim line's valid bit without touching the tag.
  always_comb begin
    w_hit_o       = 1'b0;
    w_hit_way     = '0;
    w_rd_req      = 1'b0;
    w_rd_wd       = '0;
    w_wr_en_l     = 4'b1111;
    w_wd_en       = 4'b0000;
    w_val_pulse_l = 1'b1;
    w_val_data    = 1'b0;
    w_refill_l    = 1'b1;
    w_use         = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      ST_LOOKUP: begin
        w_hit_o   = w_hit;
        w_hit_way = w_hit ? w_enc.way : bus.csh_lru_h;
      end
      ST_MREQ: begin
        w_hit_way = r_way;
        w_rd_req  = 1'b1;
        w_rd_wd   = r_wd;
        if (w_abort) w_val_pulse_l = 1'b0;
      end
      ST_FILL: begin
        w_hit_way = r_way;
        if (w_abort) begin
          w_val_pulse_l = 1'b0;
        end else if (w_beat) begin
          w_wr_en_l = ~(4'b0001 << r_way);
          w_wd_en   = onehot_wd(w_beat_wd);
        end
      end
      ST_DIRWR: begin
        w_hit_way     = r_way;
        w_refill_l    = 1'b0;
        w_val_pulse_l = 1'b0;
        w_val_data    = 1'b1;
        w_wd_en       = 4'b1111;
        w_wr_en_l     = ~(4'b0001 << r_way);
        w_done        = 1'b1;
      end
      ST_USE: begin
        w_hit_way = r_way;
        w_use     = 1'b1;
      end
      default: begin
        w_hit_way = '0;
      end
    endcase
  end

  assign bus.csh_busy_h          = (r_state != ST_IDLE);
  assign bus.csh_hit_h           = w_hit_o;
  assign bus.csh_hit_way_h       = w_hit_way;
  assign bus.mem_rd_req_h        = w_rd_req;
  assign bus.mem_rd_wd_h         = w_rd_wd;
  assign bus.csh_wr_en_l         = w_wr_en_l;
  assign bus.csh_wr_wd_en_h      = w_wd_en;
  assign bus.csh_val_wr_pulse_l  = w_val_pulse_l;
  assign bus.csh_val_wr_data_h   = w_val_data;
  assign bus.csh_refill_ram_wr_l = w_refill_l;
  assign bus.csh_use_wr_en_h     = w_use;
  assign bus.csh_fill_done_h     = w_done;
  assign bus.csh_err_h           = r_err;
  assign bus.dbg_state           = r_state;

endmodule

// File: tb/tb_csh_fill_seq.sv
// Directed plus randomized bench for csh_fill_seq, checked against a
// transaction-level model of hit/miss/refill behaviour.
module tb_csh_fill_seq;
  import csh_pkg::*;

  localparam int TMO = 255;

  logic       clk_mbx_h  = 1'b0;
  logic       mr_reset_l = 1'b0;
  int         n_cmp      = 0;
  int         n_bad      = 0;
  logic [3:0] exp_q[$];
  logic [1:0] exp_err    = 2'b00;

  csh_fill_seq_if bus();

  csh_fill_seq #(.SETTLE_CYC(1), .TIMEOUT_CYC(TMO)) dut (
    .clk_mbx_h  (clk_mbx_h),
    .mr_reset_l (mr_reset_l),
    .bus        (bus)
  );

  // clock / watchdog
  always #5 clk_mbx_h = ~clk_mbx_h;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.csh_req_h         = 1'b0;
    bus.csh_req_wd_h      = 2'd0;
    bus.csh_valid_match_h = 4'b0000;
    bus.csh_lru_h         = 2'd0;
    bus.csh_adr_par_bad_l = 1'b1;
    bus.mem_ack_h         = 1'b0;
    bus.mem_data_vld_h    = 1'b0;
    bus.mem_nxm_h         = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk_mbx_h);
  endtask

  task automatic check_quiet(input string tag);
    logic [19:0] v;
    v = {bus.csh_busy_h, bus.csh_hit_h, bus.csh_hit_way_h, bus.mem_rd_req_h,
         bus.mem_rd_wd_h, bus.csh_wr_en_l, bus.csh_wr_wd_en_h, bus.csh_val_wr_pulse_l,
         bus.csh_val_wr_data_h, bus.csh_refill_ram_wr_l, bus.csh_use_wr_en_h,
         bus.csh_fill_done_h};
    check(tag, v, 20'b0_0_00_0_00_1111_0000_1_0_1_0_0);
  endtask

  // One lookup transaction; nxm_beat / rst_beat pick the beat that aborts
  // or resets (-1 for none), no_ack lets the memory wait run out.
  task automatic run_txn(input logic [1:0] wd, input logic [3:0] match, input logic [1:0] lru,
                         input logic par_l, input int ack_dly, input int gap_max,
                         input int nxm_beat, input int rst_beat, input bit no_ack);
    bit         hit;
    logic [1:0] way;
    logic [3:0] exp_wren;
    int         waited;
    hit = ($countones(match) == 1) && par_l;
    way = lru;
    if (hit) for (int i = 0; i < 4; i++) if (match[i]) way = 2'(i);
    exp_wren = ~(4'b0001 << way);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(4'(1 << ((int'(wd) + k) % 4)));

    cyc();
    drive_idle();
    bus.csh_req_h = 1'b1; bus.csh_req_wd_h = wd; bus.csh_valid_match_h = match;
    bus.csh_lru_h = lru; bus.csh_adr_par_bad_l = par_l;
    #1;
    check_quiet("idle_before_req");
    check("err_before_req", bus.csh_err_h, exp_err);
    if (!hit && (($countones(match) > 1) || !par_l)) exp_err[0] = 1'b1;

    cyc();
    bus.csh_req_h = 1'($urandom_range(0, 1)); bus.csh_req_wd_h = 2'($urandom_range(0, 3));
    #1;
    check("settle_busy", bus.csh_busy_h, 1);
    check("settle_hit", bus.csh_hit_h, 0);

    cyc();
    #1;
    check("lookup_hit", bus.csh_hit_h, hit);
    check("lookup_rd_req", bus.mem_rd_req_h, 0);
    if (hit) check("lookup_hit_way", bus.csh_hit_way_h, way);

    if (!hit) begin
      if (no_ack) begin
        waited = 0;
        do begin
          cyc(); drive_idle(); #1;
          if (bus.csh_val_wr_pulse_l) waited++;
        end while (bus.csh_val_wr_pulse_l && waited < 400);
        check("tmo_wait_cycles", waited, TMO);
        check("tmo_val_data", bus.csh_val_wr_data_h, 0);
        check("tmo_refill_wr", bus.csh_refill_ram_wr_l, 1);
        check("tmo_wr_en", bus.csh_wr_en_l, 4'b1111);
        check("tmo_victim", bus.csh_hit_way_h, way);
        exp_err[1] = 1'b1;
        return;
      end
      for (int k = 0; k <= ack_dly; k++) begin
        cyc(); drive_idle();
        bus.mem_ack_h = (k == ack_dly);
        if (k == ack_dly) bus.mem_data_vld_h = 1'($urandom_range(0, 1));
        #1;
        check("mreq_rd_req", bus.mem_rd_req_h, 1);
        check("mreq_rd_wd", bus.mem_rd_wd_h, wd);
        check("mreq_wr_en", bus.csh_wr_en_l, 4'b1111);
      end
      for (int nb = 0; nb < 4; nb++) begin
        repeat ($urandom_range(0, gap_max)) begin
          cyc(); drive_idle(); #1;
          check("gap_wr_en", bus.csh_wr_en_l, 4'b1111);
          check("gap_wd_en", bus.csh_wr_wd_en_h, 4'b0000);
        end
        cyc(); drive_idle();
        bus.mem_data_vld_h = 1'b1;
        if (nb == nxm_beat) begin
          bus.mem_nxm_h = 1'b1;
          #1;
          check("nxm_val_pulse", bus.csh_val_wr_pulse_l, 0);
          check("nxm_val_data", bus.csh_val_wr_data_h, 0);
          check("nxm_wr_en", bus.csh_wr_en_l, 4'b1111);
          check("nxm_refill_wr", bus.csh_refill_ram_wr_l, 1);
          check("nxm_fill_done", bus.csh_fill_done_h, 0);
          exp_err[1] = 1'b1;
          return;
        end
        if (nb == rst_beat) mr_reset_l = 1'b0;
        #1;
        check("beat_wr_en", bus.csh_wr_en_l, exp_wren);
        check("beat_wd_en", bus.csh_wr_wd_en_h, exp_q.pop_front());
        if (nb == rst_beat) begin
          cyc(); drive_idle(); #1;
          check_quiet("reset_mid_fill_outs");
          check("reset_mid_fill_err", bus.csh_err_h, 0);
          check("reset_mid_fill_state", bus.dbg_state, ST_IDLE);
          exp_err = 2'b00;
          mr_reset_l = 1'b1;
          return;
        end
      end
      cyc(); drive_idle(); #1;
      check("dirwr_refill_wr", bus.csh_refill_ram_wr_l, 0);
      check("dirwr_val_pulse", bus.csh_val_wr_pulse_l, 0);
      check("dirwr_val_data", bus.csh_val_wr_data_h, 1);
      check("dirwr_wd_en", bus.csh_wr_wd_en_h, 4'b1111);
      check("dirwr_wr_en", bus.csh_wr_en_l, exp_wren);
      check("dirwr_fill_done", bus.csh_fill_done_h, 1);
      check("beats_consumed", exp_q.size(), 0);
    end

    cyc(); drive_idle(); #1;
    check("use_wr_en", bus.csh_use_wr_en_h, 1);
    check("use_way", bus.csh_hit_way_h, way);
    check("use_rd_req", bus.mem_rd_req_h, 0);
    check("use_fill_done", bus.csh_fill_done_h, 0);
  endtask

  // directed steps, then random traffic, then the report
  initial begin
    logic [3:0] m;
    int         sel;
    drive_idle();
    mr_reset_l = 1'b0;
    repeat (3) cyc();
    #1;
    check_quiet("reset_outs");
    check("reset_err", bus.csh_err_h, 0);
    check("reset_state", bus.dbg_state, ST_IDLE);
    mr_reset_l = 1'b1;

    run_txn(2'd0, 4'b0100, 2'd0, 1'b1, 0, 0, -1, -1, 1'b0);
    run_txn(2'd2, 4'b0000, 2'd1, 1'b1, 1, 0, -1, -1, 1'b0);
    run_txn(2'd1, 4'b0011, 2'd3, 1'b1, 0, 1, -1, -1, 1'b0);
    run_txn(2'd3, 4'b0001, 2'd2, 1'b0, 0, 0, -1, -1, 1'b0);
    run_txn(2'd0, 4'b0000, 2'd2, 1'b1, 0, 0, -1, -1, 1'b1);
    run_txn(2'd1, 4'b0000, 2'd3, 1'b1, 0, 1, 2, -1, 1'b0);
    run_txn(2'd2, 4'b0000, 2'd0, 1'b1, 0, 0, -1, 1, 1'b0);
    run_txn(2'd0, 4'b1000, 2'd0, 1'b1, 0, 0, -1, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      m = 4'b0000;
      else if (sel == 2) m = 4'($urandom_range(0, 15));
      else               m = 4'(1 << $urandom_range(0, 3));
      run_txn(2'($urandom_range(0, 3)), m, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 7) != 0), $urandom_range(0, 3), 2,
              ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1, -1, 1'b0);
    end

    cyc(); drive_idle(); #1;
    check_quiet("final_idle");
    check("final_err", bus.csh_err_h, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csh_fill_seq.md
Name: csh_fill_seq

Overview:
- Cache lookup/refill sequencer on the MBX side, directly downstream of the cache directory board.
- Consumes the per-way valid-match, LRU and address-parity results from the directory.
- On a hit, it reports the hit way.
- On a miss, it picks the victim way, fetches a 4-word line from memory in wrap order, then pulses the per-way/per-word write enables, the valid-write pulse and the refill-RAM write back into the directory board.

Parameters:
- WAYS, 4, cache ways (vector widths below assume 4).
- WORDS, 4, words per line; word index width = 2.
- SETTLE_CYC, 1, cycles between request accept and sampling of match lines.
- TIMEOUT_CYC, 255, maximum cycles waiting for memory ack or data before abort; 8-bit counter.

Ports:
- clk_mbx_h  in  1  cache clock.
- mr_reset_l  in  1  reset, synchronous, active-low.
- csh_req_h  in  1  lookup request, accepted only in IDLE.
- csh_req_wd_h  in  2  requested word (PMA 34:35).
- csh_valid_match_h  in  4  per-way valid match from directory.
- csh_lru_h  in  2  LRU way encoding (LRU_2 = msb).
- csh_adr_par_bad_l  in  1  directory address parity bad.
- mem_ack_h  in  1  memory accepted read request.
- mem_data_vld_h  in  1  one memory word valid this cycle.
- mem_nxm_h  in  1  nonexistent memory.
- csh_busy_h  out  1  sequencer not IDLE.
- csh_hit_h  out  1  one-cycle hit strobe.
- csh_hit_way_h  out  2  encoded hit or fill way.
- mem_rd_req_h  out  1  memory read request (level).
- mem_rd_wd_h  out  2  first word to fetch.
- csh_wr_en_l  out  4  per-way data write enable, active low.
- csh_wr_wd_en_h  out  4  one-hot word write enable.
- csh_val_wr_pulse_l  out  1  valid-bit write pulse.
- csh_val_wr_data_h  out  1  valid data written.
- csh_refill_ram_wr_l  out  1  directory tag write pulse.
- csh_use_wr_en_h  out  1  LRU/use update strobe.
- csh_fill_done_h  out  1  one-cycle fill complete.
- csh_err_h  out  2  sticky: bit0 parity or multi-hit, bit1 timeout/NXM; cleared by reset only.

Behaviour:
- Reset values (and values in IDLE): all _l outputs 1; all _h outputs 0; state IDLE; counters 0; csh_err_h = 0.
- States: IDLE, SETTLE, LOOKUP, MREQ, FILL, DIRWR, USE.
- IDLE:
  - csh_req_h = 1 → SETTLE; latch csh_req_wd_h.
  - Requests outside IDLE are ignored.
- SETTLE: counts SETTLE_CYC cycles, then → LOOKUP.
- LOOKUP samples csh_valid_match_h:
  - Exactly one bit set and parity good: csh_hit_h = 1, way encoded, → USE.
  - Zero bits set: → MREQ; victim = csh_lru_h.
  - More than one bit set, or csh_adr_par_bad_l = 0: set err bit0, treat as miss, victim = csh_lru_h.
- MREQ:
  - mem_rd_req_h = 1; mem_rd_wd_h = latched word.
  - mem_ack_h → FILL.
- FILL: each mem_data_vld_h cycle writes one word:
  - csh_wr_en_l[victim] = 0.
  - csh_wr_wd_en_h one-hot at word (start + n) mod 4; wraps 3 → 0.
  - n increments.
  - After the 4th word → DIRWR.
  - mem_data_vld_h asserted together with mem_ack_h in the MREQ cycle is ignored.
- DIRWR (1 cycle):
  - csh_refill_ram_wr_l = 0.
  - csh_val_wr_pulse_l = 0, csh_val_wr_data_h = 1.
  - csh_wr_wd_en_h = 4'b1111, csh_wr_en_l[victim] = 0.
  - csh_fill_done_h = 1.
  - → USE.
- USE (1 cycle): csh_use_wr_en_h = 1, csh_hit_way_h held; → IDLE.
- Hit latency: strobe SETTLE_CYC+1 cycles after request accept. Miss minimum: ack cycle + 4 data cycles + DIRWR + USE.
- Timeout counter:
  - Resets on entry to MREQ and on each ack/data.
  - Reaching TIMEOUT_CYC, or mem_nxm_h = 1 in MREQ/FILL: set err bit1, csh_val_wr_pulse_l = 0 with csh_val_wr_data_h = 0 for victim (invalidate line), no tag write, → IDLE.
- Synchronous reset mid-fill: next edge → IDLE with all strobes deasserted. A partially written line is not validated.
- csh_wr_en_l has at most one bit low in any cycle.

Decomposition:
- Package csh_pkg:
  - state enum csh_fill_st_t.
  - WAYS, WORDS, way/word index typedefs.
  - function onehot_wd(idx) and function enc_way(vec) returning way + multi-hit flag.
- One sub-module: csh_fill_tmo (timeout counter, load/clear/expire); the rest is a single FSM.

Test Plan:
- Hit way 2: csh_req_h = 1, match = 4'b0100 → csh_hit_h after 2 cycles, way = 2, csh_use_wr_en_h next cycle, no mem_rd_req_h.
- Miss with wrap: req_wd = 2, match = 0, lru = 1, ack, 4 data beats → csh_wr_en_l = 4'b1101, wd_en 0100, 1000, 0001, 0010; then DIRWR pulses plus csh_fill_done_h.
- Multi-hit: match = 4'b0011 → err bit0 set, miss fill into LRU way; same with csh_adr_par_bad_l = 0 and match = 0001.
- Timeout: miss, no ack for 255 cycles → err bit1, valid pulse with data 0, no refill_ram_wr, back to IDLE.
- NXM during FILL after 2 words → abort, invalidate, csh_busy_h = 0 next cycle.
- Reset during FILL word 1 → all outputs at reset values next edge; new request then hits normally.
